// File: rtl/toggle_event_decoder.sv
// rtl/toggle_event_decoder.sv - toggle-encoded event receiver with pending queue and toggle ack
// Optional total-event counter built only when TOGDEC_TOTAL_CNT_EN is defined.
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int TOTAL_W     = 16
) (
  input  logic               clock,
  input  logic               clear_,
  input  logic               tog_in,
  input  logic               clr_ovf,
  output logic               evt_pulse,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [CNT_W-1:0]   pending,
  output logic               overflow,
  output logic               ack_q,
  output logic [TOTAL_W-1:0] total
);

  localparam int WCW = $clog2(SYNC_STAGES + 2);
  localparam logic [WCW-1:0]   WARM_LOAD = WCW'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {WARMUP = 1'b0, RUN = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WCW-1:0]         r_warm_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   r_pulse;
  logic [CNT_W-1:0]       r_pending;
  logic                   r_overflow;
  logic                   r_ack;

  logic w_sync_q;
  logic w_det;
  logic w_inc;
  logic w_dec;
  logic w_sat;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_det    = w_sync_q ^ r_sync_d;
  assign w_inc    = r_pulse;
  assign w_dec    = (r_pending != '0) && evt_ready;
  assign w_sat    = w_inc && !w_dec && (r_pending == CNT_MAX);

  always_ff @(posedge clock or negedge clear_) begin
    if (!clear_) begin
      r_state    <= WARMUP;
      r_warm_cnt <= WARM_LOAD;
    end else begin
      r_state <= w_state_next;
      if (r_state == WARMUP && r_warm_cnt != '0)
        r_warm_cnt <= r_warm_cnt - 1'b1;
    end
  end

  // Leave WARMUP on the edge where the counter lands on zero; by then sync_d has caught up.
  always_comb begin
    w_state_next = r_state;
    if (r_state == WARMUP && r_warm_cnt == WCW'(1))
      w_state_next = RUN;
  end

  always_ff @(posedge clock or negedge clear_) begin
    if (!clear_) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], tog_in};
      r_sync_d <= w_sync_q;
      r_pulse  <= w_det && (r_state == RUN);
    end
  end

  always_ff @(posedge clock or negedge clear_) begin
    if (!clear_) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_ack      <= 1'b0;
    end else begin
      if (w_inc && !w_dec && !w_sat)
        r_pending <= r_pending + 1'b1;
      else if (w_dec && !w_inc)
        r_pending <= r_pending - 1'b1;
      if (w_sat)
        r_overflow <= 1'b1;
      else if (clr_ovf)
        r_overflow <= 1'b0;
      if (w_dec)
        r_ack <= ~r_ack;
    end
  end

`ifdef TOGDEC_TOTAL_CNT_EN
  logic [TOTAL_W-1:0] r_total;
  always_ff @(posedge clock or negedge clear_) begin
    if (!clear_)
      r_total <= '0;
    else if (w_inc)
      r_total <= r_total + 1'b1;
  end
  assign total = r_total;
`else
  assign total = '0;
`endif

  assign evt_pulse = r_pulse;
  assign evt_valid = (r_pending != '0);
  assign pending   = r_pending;
  assign overflow  = r_overflow;
  assign ack_q     = r_ack;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb/tb_toggle_event_decoder.sv - directed self-checking bench for toggle_event_decoder
module tb_toggle_event_decoder;

  logic        clock;
  logic        clear_;
  logic        tog_in;
  logic        clr_ovf;
  logic        evt_pulse;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  pending;
  logic        overflow;
  logic        ack_q;
  logic [15:0] total;

  int n_vec;
  int n_err;
  int pulses;

  toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(4), .TOTAL_W(16)) dut (
    .clock     (clock),
    .clear_    (clear_),
    .tog_in    (tog_in),
    .clr_ovf   (clr_ovf),
    .evt_pulse (evt_pulse),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow),
    .ack_q     (ack_q),
    .total     (total)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (evt_pulse === 1'b1) pulses++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse"},    32'(evt_pulse), 0);
    check({tag, "_valid"},    32'(evt_valid), 0);
    check({tag, "_pending"},  32'(pending),   0);
    check({tag, "_overflow"}, 32'(overflow),  0);
    check({tag, "_ack"},      32'(ack_q),     0);
    check({tag, "_total"},    32'(total),     0);
  endtask

  function automatic logic [31:0] exp_total(input int n);
`ifdef TOGDEC_TOTAL_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  initial begin
    n_vec = 0; n_err = 0; pulses = 0;
    clear_ = 1'b0; tog_in = 1'b1; clr_ovf = 1'b0; evt_ready = 1'b0;
    tick(); tick();
    check_zero("reset");

    // tog_in held high across reset release must not produce an event
    clear_ = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) tick();
    check("warmup_pulses", 32'(pulses), 0);
    check("warmup_pending", 32'(pending), 0);
    check("warmup_ack", 32'(ack_q), 0);

    // single toggle: pulse appears after the third edge, exactly one cycle
    tog_in = ~tog_in;
    tick(); check("lat_e1", 32'(evt_pulse), 0);
    tick(); check("lat_e2", 32'(evt_pulse), 0);
    tick(); check("lat_e3", 32'(evt_pulse), 1);
    tick(); check("lat_e4", 32'(evt_pulse), 0);
    check("single_pending", 32'(pending), 1);
    check("single_valid", 32'(evt_valid), 1);
    check("single_total", 32'(total), exp_total(1));

    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("accept_pending", 32'(pending), 0);
    check("accept_valid", 32'(evt_valid), 0);
    check("accept_ack", 32'(ack_q), 1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("empty_ready_ack", 32'(ack_q), 1);
    check("empty_ready_pending", 32'(pending), 0);

    // 16 toggles two cycles apart saturate the 4-bit pending counter
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tog_in = ~tog_in;
      tick(); tick();
    end
    for (int i = 0; i < 4; i++) tick();
    check("burst_pulses", 32'(pulses), 16);
    check("sat_pending", 32'(pending), 15);
    check("sat_overflow", 32'(overflow), 1);
    check("sat_total", 32'(total), exp_total(17));

    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    evt_ready = 1'b0;
    check("drain_pending", 32'(pending), 5);
    check("drain_ack", 32'(ack_q), 1);

    // detection coincident with acceptance leaves pending unchanged
    tog_in = ~tog_in;
    tick(); tick(); tick();
    check("coinc_pulse", 32'(evt_pulse), 1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("coinc_pending", 32'(pending), 5);
    check("coinc_ack", 32'(ack_q), 0);
    check("coinc_total", 32'(total), exp_total(18));

    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 0);

    for (int i = 0; i < 10; i++) begin
      tog_in = ~tog_in;
      tick(); tick();
    end
    for (int i = 0; i < 4; i++) tick();
    check("refill_pending", 32'(pending), 15);
    check("refill_overflow", 32'(overflow), 0);

    // set beats clear when a new overflow lands with clr_ovf
    tog_in = ~tog_in;
    tick(); tick(); tick();
    check("ovf2_pulse", 32'(evt_pulse), 1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(overflow), 1);
    check("ovf2_pending", 32'(pending), 15);
    check("ovf2_total", 32'(total), exp_total(29));

    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    evt_ready = 1'b0;
    check("pre_reset_pending", 32'(pending), 7);

    // asynchronous reset mid-cycle clears outputs before the next edge
    #2;
    clear_ = 1'b0;
    #1;
    check_zero("async_reset");
    tog_in = ~tog_in;
    tick();
    clear_ = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) tick();
    check("post_reset_pulses", 32'(pulses), 0);
    check("post_reset_pending", 32'(pending), 0);
    check("post_reset_ack", 32'(ack_q), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
